// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard and forwarding unit: per-register producer-latency scoreboard
// driving operand forwarding selects and the pipeline stall.
module id_hazard_scoreboard #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned MAXLAT = 3,
    localparam int unsigned RW    = $clog2(NREG),
    localparam int unsigned CW    = $clog2(MAXLAT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic              id_we,
    input  logic [RW-1:0]     id_rd,
    input  logic [CW-1:0]     id_lat,
    input  logic [NRD*RW-1:0] id_rs,
    input  logic [NRD-1:0]    id_rs_use,
    input  logic              flush_ex,
    input  logic              mem_we,
    input  logic [RW-1:0]     mem_rd,
    input  logic              wb_we,
    input  logic [RW-1:0]     wb_rd,
    output logic [NRD*2-1:0]  fwd_sel,
    output logic              stall,
    output logic [31:0]       stall_cycles
);

    localparam logic [CW-1:0] MAXLATC = CW'(MAXLAT);

    logic [CW-1:0] cnt [NREG];
    logic [RW-1:0] lastRd;
    logic          lastV;

    logic [RW-1:0] rsPort [NRD];
    logic [NRD-1:0] portHaz;
    logic [CW-1:0] latClamp;
    logic          issue;
    logic          writeNew;

    for (genvar k = 0; k < NRD; k++) begin : gPort
        logic memHit;
        logic wbHit;
        logic portLive;

        assign rsPort[k]  = id_rs[k*RW +: RW];
        assign portLive   = id_rs_use[k] & (rsPort[k] != '0);
        assign portHaz[k] = id_valid & portLive & (cnt[rsPort[k]] != '0);
        assign memHit     = mem_we & (mem_rd == rsPort[k]);
        assign wbHit      = wb_we & (wb_rd == rsPort[k]);
        // MEM holds the younger result, so it takes precedence over WB.
        assign fwd_sel[k*2 +: 2] = (!stall && portLive) ?
                                   (memHit ? 2'b10 : (wbHit ? 2'b01 : 2'b00)) : 2'b00;
    end

    assign stall    = |portHaz;
    assign issue    = id_valid & ~stall;
    assign writeNew = issue & id_we & (id_rd != '0);
    assign latClamp = (id_lat > MAXLATC) ? MAXLATC : id_lat;

    // x0 is never written outside reset, so cnt[0] stays zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            lastV        <= 1'b0;
            lastRd       <= '0;
            stall_cycles <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (writeNew && id_rd == RW'(r)) begin
                    cnt[r] <= latClamp;
                end else if (flush_ex && lastV && lastRd == RW'(r)) begin
                    cnt[r] <= '0;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
            lastV  <= writeNew;
            lastRd <= id_rd;
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule
